// File: rtl/uop_pkg.sv
// Shared micro-op bundle types for the front-end to execute interface.
package uop_pkg;

  localparam int UOP_W     = 20;
  localparam int K_W       = 16;
  localparam int UOP_SLOTS = 3;

  typedef struct packed {
    logic [UOP_SLOTS-1:0][UOP_W-1:0] uop;
    logic [1:0]                      count;
    logic [K_W-1:0]                  k;
  } uop_bundle_t;

  // Slot index of the final micro-op of a bundle holding `count` ops.
  function automatic logic [1:0] last_slot(input logic [1:0] count);
    return count - 2'd1;
  endfunction

endpackage

// File: rtl/uop_bundle_fifo.sv
// Bundle storage FIFO: wrap-bit pointers, full/empty flags and occupancy.
module uop_bundle_fifo
  import uop_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  uop_bundle_t                i_data,
  output uop_bundle_t                o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  uop_bundle_t r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;
  logic [AW:0] w_diff;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_do_push = i_push & ~o_full & ~i_clear;
  assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
  assign w_diff    = r_wptr - r_rptr;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_head      = r_mem[r_rptr[AW-1:0]];
  assign o_occupancy = OCC_W'(w_diff);

endmodule

// File: rtl/uop_issue_queue.sv
// Micro-op issue queue: buffers decoded bundles and issues one micro-op per cycle.
// Optional zero-cycle bypass into an empty queue is enabled by defining UIQ_BYPASS_EN.
module uop_issue_queue
  import uop_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       flush,
  output logic                       feed_req,
  input  logic                       feed_ack,
  input  logic [UOP_W-1:0]           in_uop_0,
  input  logic [UOP_W-1:0]           in_uop_1,
  input  logic [UOP_W-1:0]           in_uop_2,
  input  logic [1:0]                 in_uop_count,
  input  logic [K_W-1:0]             in_k,
  output logic                       uop_valid,
  input  logic                       uop_ready,
  output logic [UOP_W-1:0]           uop_out,
  output logic [K_W-1:0]             uop_k,
  output logic                       uop_last,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  uop_bundle_t      w_in_bundle;
  uop_bundle_t      w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push_nz;
  logic             w_byp;
  logic             w_valid;
  logic [UOP_W-1:0] w_cur_uop;
  logic [K_W-1:0]   w_cur_k;
  logic             w_cur_last;
  logic             w_fire;
  logic             w_pop;
  logic             w_store;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;

  assign w_in_bundle.uop   = {in_uop_2, in_uop_1, in_uop_0};
  assign w_in_bundle.count = in_uop_count;
  assign w_in_bundle.k     = in_k;

  assign feed_req  = ~w_full & ~flush;
  assign w_push_nz = feed_req & feed_ack & (in_uop_count != 2'd0);

`ifdef UIQ_BYPASS_EN
  assign w_byp = w_empty & w_push_nz;
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid    = ~w_empty | w_byp;
  assign w_cur_uop  = w_byp ? in_uop_0 : w_head.uop[r_idx];
  assign w_cur_k    = w_byp ? in_k : w_head.k;
  assign w_cur_last = w_byp ? (in_uop_count == 2'd1) : (r_idx == last_slot(w_head.count));

  assign w_fire  = w_valid & uop_ready & ~flush;
  assign w_pop   = w_fire & w_cur_last & ~w_byp;
  // A single-op bundle issued straight through the bypass never needs a slot.
  assign w_store = w_push_nz & ~(w_byp & w_fire & w_cur_last);

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_idx_nxt = r_idx;
    if (flush) begin
      w_idx_nxt = 2'd0;
    end else if (w_byp) begin
      w_idx_nxt = (w_fire & ~w_cur_last) ? 2'd1 : 2'd0;
    end else if (w_fire) begin
      w_idx_nxt = w_cur_last ? 2'd0 : r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) r_idx <= 2'd0;
    else        r_idx <= w_idx_nxt;
  end

  uop_bundle_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .a_rst       (a_rst),
    .i_clear     (flush),
    .i_push      (w_store),
    .i_pop       (w_pop),
    .i_data      (w_in_bundle),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_occupancy (occupancy)
  );

  // Outputs are forced to zero when nothing is valid, so stale storage never leaks out.
  assign uop_valid = w_valid;
  assign uop_out   = w_valid ? w_cur_uop : '0;
  assign uop_k     = w_valid ? w_cur_k : '0;
  assign uop_last  = w_valid & w_cur_last;

endmodule

// File: tb/tb_uop_issue_queue.sv
// Self-checking bench for uop_issue_queue: directed vector table plus randomized model check.
module tb_uop_issue_queue;

  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             a_rst;
  logic             flush;
  logic             feed_req;
  logic             feed_ack;
  logic [19:0]      in_uop_0, in_uop_1, in_uop_2;
  logic [1:0]       in_uop_count;
  logic [15:0]      in_k;
  logic             uop_valid;
  logic             uop_ready;
  logic [19:0]      uop_out;
  logic [15:0]      uop_k;
  logic             uop_last;
  logic [OCC_W-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uop_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .a_rst(a_rst), .flush(flush), .feed_req(feed_req), .feed_ack(feed_ack),
    .in_uop_0(in_uop_0), .in_uop_1(in_uop_1), .in_uop_2(in_uop_2),
    .in_uop_count(in_uop_count), .in_k(in_k), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_out(uop_out), .uop_k(uop_k), .uop_last(uop_last), .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic ack, input logic [1:0] cnt,
                       input logic [19:0] u0, input logic [19:0] u1, input logic [19:0] u2,
                       input logic [15:0] k, input logic rdy);
    flush = fl; feed_ack = ack; in_uop_count = cnt;
    in_uop_0 = u0; in_uop_1 = u1; in_uop_2 = u2; in_k = k; uop_ready = rdy;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [19:0] eo,
                            input logic [15:0] ek, input logic el, input int eocc, input logic efr);
    check({tag, ".valid"}, 32'(uop_valid), 32'(ev));
    check({tag, ".out"},   32'(uop_out),   32'(eo));
    check({tag, ".k"},     32'(uop_k),     32'(ek));
    check({tag, ".last"},  32'(uop_last),  32'(el));
    check({tag, ".occ"},   32'(occupancy), 32'(eocc));
    check({tag, ".freq"},  32'(feed_req),  32'(efr));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic fl, ack; logic [1:0] cnt; logic [19:0] u0, u1, u2; logic [15:0] k; logic rdy;
    logic ev; logic [19:0] eo; logic [15:0] ek; logic el; int eocc; logic efr;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic fl, logic ack, logic [1:0] cnt, logic [19:0] u0,
                              logic [19:0] u1, logic [19:0] u2, logic [15:0] k, logic rdy,
                              logic ev, logic [19:0] eo, logic [15:0] ek, logic el,
                              int eocc, logic efr);
    vec_t v;
    v.fl = fl; v.ack = ack; v.cnt = cnt; v.u0 = u0; v.u1 = u1; v.u2 = u2; v.k = k; v.rdy = rdy;
    v.ev = ev; v.eo = eo; v.ek = ek; v.el = el; v.eocc = eocc; v.efr = efr;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [19:0] u[3]; int cnt; logic [15:0] k; } mb_t;
  mb_t q[$];
  int  m_idx = 0;
  logic m_v, m_l, m_fr, m_push, m_byp;
  logic [19:0] m_o;
  logic [15:0] m_k;

  task automatic m_eval();
    m_fr   = (q.size() < DEPTH) && !flush;
    m_push = m_fr && feed_ack && (in_uop_count != 0);
    m_byp  = 1'b0;
`ifdef UIQ_BYPASS_EN
    m_byp  = (q.size() == 0) && m_push;
`endif
    if (m_byp) begin
      m_v = 1'b1; m_o = in_uop_0; m_k = in_k; m_l = (in_uop_count == 1);
    end else if (q.size() > 0) begin
      m_v = 1'b1; m_o = q[0].u[m_idx]; m_k = q[0].k; m_l = (m_idx == q[0].cnt - 1);
    end else begin
      m_v = 1'b0; m_o = '0; m_k = '0; m_l = 1'b0;
    end
  endtask

  task automatic m_step();
    mb_t nb;
    logic fire;
    nb.u[0] = in_uop_0; nb.u[1] = in_uop_1; nb.u[2] = in_uop_2;
    nb.cnt = int'(in_uop_count); nb.k = in_k;
    fire = m_v && uop_ready;
    if (flush) begin
      q.delete(); m_idx = 0;
    end else if (m_byp) begin
      if (!(fire && nb.cnt == 1)) begin
        q.push_back(nb);
        m_idx = fire ? 1 : 0;
      end
    end else begin
      if (fire) begin
        if (m_l) begin q.pop_front(); m_idx = 0; end
        else m_idx++;
      end
      if (m_push) q.push_back(nb);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
    q.delete(); m_idx = 0;
  endtask

  initial begin
    a_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    a_rst = 1'b1;

`ifndef UIQ_BYPASS_EN
    // single 3-op bundle
    vecs.push_back(mk(0,1,3,20'h1,20'h2,20'h3,16'h1234,1, 0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'h1,16'h1234,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'h2,16'h1234,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'h3,16'h1234,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
    // fill to DEPTH, third ack ignored, drain
    vecs.push_back(mk(0,1,1,20'h11,0,0,16'h0011,0,        0,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,20'h22,0,0,16'h0022,0,        1,20'h11,16'h0011,1,1,1));
    vecs.push_back(mk(0,1,1,20'h33,0,0,16'h0033,0,        1,20'h11,16'h0011,1,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'h11,16'h0011,1,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,                    1,20'h22,16'h0022,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'h22,16'h0022,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
    // zero-count bundle
    vecs.push_back(mk(0,1,0,20'h55,0,0,16'h0055,1,        0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
    // flush mid-bundle with a queued bundle and a coincident feed_ack
    vecs.push_back(mk(0,1,3,20'hA1,20'hA2,20'hA3,16'hAAAA,0, 0,0,0,0,0,1));
    vecs.push_back(mk(0,1,1,20'hB1,0,0,16'hBBBB,1,        1,20'hA1,16'hAAAA,0,1,1));
    vecs.push_back(mk(1,1,2,20'hC1,20'hC2,0,16'hCCCC,0,   1,20'hA2,16'hAAAA,0,2,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
    // stall stability for 5 cycles at idx=1
    vecs.push_back(mk(0,1,2,20'hD1,20'hD2,0,16'hDDDD,0,   0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'hD1,16'hDDDD,0,1,1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,0,0,0,0,                  1,20'hD2,16'hDDDD,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'hD2,16'hDDDD,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
`else
    // 2-op bundle bypassed into an empty queue
    vecs.push_back(mk(0,1,2,20'hAAAAA,20'hBBBBB,0,16'h5A5A,1, 1,20'hAAAAA,16'h5A5A,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'hBBBBB,16'h5A5A,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
    // flush suppresses bypass
    vecs.push_back(mk(1,1,1,20'h77,0,0,16'h7777,1,        0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
    // fired single-op bypass is never stored
    vecs.push_back(mk(0,1,1,20'h99,0,0,16'h0099,1,        1,20'h99,16'h0099,1,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
    // unfired bypass is stored at idx 0
    vecs.push_back(mk(0,1,1,20'h44,0,0,16'h0044,0,        1,20'h44,16'h0044,1,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    1,20'h44,16'h0044,1,1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,                    0,0,0,0,0,1));
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].ack, vecs[i].cnt, vecs[i].u0, vecs[i].u1, vecs[i].u2,
            vecs[i].k, vecs[i].rdy);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].ek, vecs[i].el,
                 vecs[i].eocc, vecs[i].efr);
    end

    // randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive(($urandom_range(31) == 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
            20'($urandom), 20'($urandom), 20'($urandom), 16'($urandom),
            ($urandom_range(3) != 0));
      #1;
      m_eval();
      check_outs($sformatf("rnd%0d", c), m_v, m_o, m_k, m_l, q.size(), m_fr);
      m_step();
    end

    // asynchronous reset mid-bundle
    @(negedge clk);
    drive(0, 1, 3, 20'hE1, 20'hE2, 20'hE3, 16'hEEEE, 0);
    #1;
    m_eval();
    m_step();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("prereset.occ", 32'(occupancy), 32'(q.size()));
    a_rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    a_rst = 1'b1;
    q.delete(); m_idx = 0;
    @(negedge clk);
    #1;
    check_outs("post_rst", 0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
